fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the combinational instruction memory: owns the program counter and drives its
//  Address, captures each returned Instruction into a small fetch queue, and hands
//  {PC, Instruction} to the IF/ID stage over a valid/ready handshake. It accepts redirects
//  from branch/jump resolution, flushes wrong-path entries and traps illegal fetch addresses.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset release
//  IMEM_WORDS  512            words addressable in instruction memory (Address[10:2])
//  QUEUE_DEPTH 2              fetch-queue entries (power of 2, >=2)
// PORTS
//  Clk_in          in   1   single clock, all state on rising edge
//  Rst_n           in   1   reset, asynchronous assert, active-low
//  Imem_Address    out  32  byte address to instruction memory (= fetch_pc)
//  Imem_Instr      in   32  combinational read data for Imem_Address
//  Redirect_in     in   1   branch/jump taken this cycle
//  Redirect_PC_in  in   32  redirect target byte address
//  Out_Valid       out  1   queue head valid
//  Out_Ready       in   1   IF/ID accepts head this cycle
//  Out_Instr       out  32  head instruction
//  Out_PC          out  32  head PC
//  Out_PCPlus4     out  32  head PC + 4
//  Fault_out       out  1   illegal fetch address trapped (sticky until cleared)
//  Fault_PC        out  32  offending address
// BEHAVIOUR
//  Reset (Rst_n=0, async): fetch_pc=RESET_PC, queue empty, state=FETCH; Out_Valid=0,
//   Out_Instr/Out_PC/Fault_PC=0, Out_PCPlus4=4, Fault_out=0.
//  States: FETCH, FAULT.
//  FETCH: each cycle queue not full (or a pop frees a slot same cycle): push {fetch_pc,
//   Imem_Instr}, fetch_pc += 4 (32-bit wrap irrelevant: bound check below). Queue full and
//   no pop: hold fetch_pc, no push.
//  Latency: first Out_Valid=1 one cycle after Rst_n deassert; steady state 1 instr/cycle.
//  Handshake: transfer when Out_Valid&Out_Ready; head stable while Out_Valid&!Out_Ready.
//  Redirect_in=1 (priority over push): a transfer occurring the same cycle still counts;
//   all other entries flushed; next cycle fetch_pc=Redirect_PC_in, Out_Valid=0; target
//   instruction appears Out_Valid=1 the following cycle (1-bubble penalty).
//  Illegal target: Redirect_PC_in[1:0]!=0 or Redirect_PC_in>=IMEM_WORDS*4 -> flush,
//   state=FAULT, Fault_out=1, Fault_PC=target next cycle.
//  Sequential overrun: fetch_pc reaches IMEM_WORDS*4 in FETCH -> no push; FAULT with
//   Fault_PC=fetch_pc; entries already queued still drain normally.
//  FAULT: no fetch, no push; exits to FETCH only on a legal redirect (Fault_out cleared,
//   Fault_PC held); illegal redirect in FAULT updates Fault_PC.
//  Queue full and redirect same cycle: flush wins. Empty and Out_Ready=1: no effect.
//  Rst_n asserted mid-operation: immediate clear to reset values, queue contents dropped.
// STRUCTURE
//  Package fetch_pkg: RESET_PC default, IMEM_WORDS, state enum {FETCH, FAULT},
//   fetch-entry struct {pc[31:0], instr[31:0]}.
//  Sub-module fetch_queue: QUEUE_DEPTH-entry FIFO with push, pop, flush, full, empty;
//   flush has priority over push, pop of head allowed in the same cycle as flush.
//  Top: PC register, bound/alignment check, FSM, output muxing from queue head.
// TESTING
//  1 Release reset, Out_Ready=1, memory[i]=i*3 -> Out_PC 0,4,8.. each cycle, Out_Instr 0,3,6.
//  2 Out_Ready=0 for 5 cycles after 1st valid -> Imem_Address stops at 8 (2 queued),
//    head holds PC 0; Out_Ready=1 -> PCs 0,4,8 delivered in order, no loss or duplication.
//  3 Redirect_in to 0x40 while head PC=0x8 accepted -> 0x8 transferred, 0x0C dropped,
//    next cycle Out_Valid=0, following cycle Out_PC=0x40, Out_Instr=48.
//  4 Redirect to 0x42 -> Fault_out=1, Fault_PC=0x42, no pushes; then redirect 0x10 ->
//    Fault_out=0, Out_PC=0x10 two cycles later.
//  5 Redirect to 0x7FC (last word), Out_Ready=1 -> one instr PC=0x7FC, then Fault_out=1,
//    Fault_PC=0x800.
//  6 Rst_n pulsed low between edges with 2 queued -> outputs clear immediately; after release
//    Out_PC restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer.
//   - default reset PC, instruction-memory size and fetch-queue depth
//   - fetch_state_e : sequencer FSM states
//   - fetch_entry_t : one fetch-queue entry {pc, instr}
//   - addr_legal()  : word-aligned and inside instruction memory
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
    localparam int unsigned IMEM_WORDS_DEFAULT  = 512;
    localparam int unsigned QUEUE_DEPTH_DEFAULT = 2;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // limit is the memory size in bytes. It is 33 bits wide so that a
    // memory covering the full 4 GiB space can still be described.
    function automatic logic addr_legal(input logic [31:0] addr,
                                        input logic [32:0] limit);
        return (addr[1:0] == 2'b00) && ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          write push_data_i (accepted when not full, or when a pop frees a slot)
//   pop_i           drop the head entry (ignored when empty)
//   flush_i         discard all entries; overrides push; a same-cycle pop is harmless
//   push_data_i     entry to write
//   head_o          oldest entry (meaningful only when !empty_o)
//   empty_o/full_o  occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = QUEUE_DEPTH_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t push_data_i,
    output fetch_entry_t head_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               do_push;
    logic               do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // When full, a pop in the same cycle frees the slot we are writing.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, reads a combinational instruction
// memory, buffers fetched words in a small queue and presents the head to IF/ID.
// Ports:
//   Clk_in, Rst_n             clock, asynchronous active-low reset
//   Imem_Address / Imem_Instr byte address out, combinational instruction in
//   Redirect_in/Redirect_PC_in taken branch/jump and its target
//   Out_Valid/Out_Ready       head handshake: a transfer happens when both are 1;
//                             while Out_Valid=1 and Out_Ready=0 the head is held
//   Out_Instr/Out_PC/Out_PCPlus4  head entry (zero / 4 when the queue is empty)
//   Fault_out/Fault_PC        illegal-fetch trap flag and offending address
//   Dbg_State_o               current FSM state
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_WORDS  = IMEM_WORDS_DEFAULT,
    parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT
) (
    input  logic         Clk_in,
    input  logic         Rst_n,
    output logic [31:0]  Imem_Address,
    input  logic [31:0]  Imem_Instr,
    input  logic         Redirect_in,
    input  logic [31:0]  Redirect_PC_in,
    output logic         Out_Valid,
    input  logic         Out_Ready,
    output logic [31:0]  Out_Instr,
    output logic [31:0]  Out_PC,
    output logic [31:0]  Out_PCPlus4,
    output logic         Fault_out,
    output logic [31:0]  Fault_PC,
    output fetch_state_e Dbg_State_o
);

    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

    fetch_state_e state_q;
    logic [31:0]  fetch_pc_q;
    logic         fault_q;
    logic [31:0]  fault_pc_q;

    fetch_entry_t q_head;
    fetch_entry_t q_push_data;
    logic         q_push;
    logic         q_pop;
    logic         q_flush;
    logic         q_empty;
    logic         q_full;

    logic         redirect_legal;
    logic         pc_legal;

    assign redirect_legal = addr_legal(Redirect_PC_in, IMEM_BYTES);
    assign pc_legal       = addr_legal(fetch_pc_q, IMEM_BYTES);

    assign q_pop       = !q_empty && Out_Ready;
    // A redirect discards everything still queued; the head may still
    // transfer in that same cycle because q_pop is unaffected.
    assign q_flush     = Redirect_in;
    assign q_push      = (state_q == FETCH) && !Redirect_in && pc_legal &&
                         (!q_full || q_pop);
    assign q_push_data = '{pc: fetch_pc_q, instr: Imem_Instr};

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk_i      (Clk_in),
        .rst_ni     (Rst_n),
        .push_i     (q_push),
        .pop_i      (q_pop),
        .flush_i    (q_flush),
        .push_data_i(q_push_data),
        .head_o     (q_head),
        .empty_o    (q_empty),
        .full_o     (q_full)
    );

    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else if (Redirect_in) begin
            // Redirect is honoured in either state.
            if (redirect_legal) begin
                state_q    <= FETCH;
                fetch_pc_q <= Redirect_PC_in;
                fault_q    <= 1'b0;
            end else begin
                state_q    <= FAULT;
                fault_q    <= 1'b1;
                fault_pc_q <= Redirect_PC_in;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (!pc_legal) begin
                        // Ran off the end of memory; queued entries still drain.
                        state_q    <= FAULT;
                        fault_q    <= 1'b1;
                        fault_pc_q <= fetch_pc_q;
                    end else if (q_push) begin
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                    end
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign Imem_Address = fetch_pc_q;
    assign Out_Valid    = !q_empty;
    assign Out_PC       = q_empty ? 32'd0 : q_head.pc;
    assign Out_Instr    = q_empty ? 32'd0 : q_head.instr;
    assign Out_PCPlus4  = Out_PC + 32'd4;
    assign Fault_out    = fault_q;
    assign Fault_PC     = fault_pc_q;
    assign Dbg_State_o  = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  imem_address;
  logic [31:0]  imem_instr;
  logic         redirect = 1'b0;
  logic [31:0]  redirect_pc = 32'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_instr;
  logic [31:0]  out_pc;
  logic [31:0]  out_pcplus4;
  logic         fault;
  logic [31:0]  fault_pc;
  fetch_state_e dbg_state;

  logic [31:0] mem [512];
  assign imem_instr = mem[imem_address[10:2]];

  fetch_sequencer dut (
    .Clk_in        (clk),
    .Rst_n         (rst_n),
    .Imem_Address  (imem_address),
    .Imem_Instr    (imem_instr),
    .Redirect_in   (redirect),
    .Redirect_PC_in(redirect_pc),
    .Out_Valid     (out_valid),
    .Out_Ready     (out_ready),
    .Out_Instr     (out_instr),
    .Out_PC        (out_pc),
    .Out_PCPlus4   (out_pcplus4),
    .Fault_out     (fault),
    .Fault_PC      (fault_pc),
    .Dbg_State_o   (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // exp_q holds {pc, instr} of entries waiting to be handed over, oldest first.
  localparam int unsigned MEM_BYTES = 512 * 4;
  localparam int unsigned QDEPTH = 2;
  logic [63:0] exp_q[$];
  logic [31:0] m_pc = 32'd0;
  logic        m_fault = 1'b0;
  logic [31:0] m_fault_pc = 32'd0;

  function automatic logic legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < MEM_BYTES);
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      exp_q.delete();
      m_pc = 32'd0;
      m_fault = 1'b0;
      m_fault_pc = 32'd0;
    end else begin
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (redirect) begin
        exp_q.delete();
        if (legal(redirect_pc)) begin
          m_fault = 1'b0;
          m_pc = redirect_pc;
        end else begin
          m_fault = 1'b1;
          m_fault_pc = redirect_pc;
        end
      end else if (!m_fault) begin
        if (!legal(m_pc)) begin
          m_fault = 1'b1;
          m_fault_pc = m_pc;
        end else if (exp_q.size() < QDEPTH) begin
          exp_q.push_back({m_pc, mem[m_pc / 4]});
          m_pc = m_pc + 4;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  initial forever begin
    @(negedge clk);
    check("valid", 32'(out_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check("out_pc", out_pc, exp_q[0][63:32]);
      check("out_instr", out_instr, exp_q[0][31:0]);
      check("out_pcplus4", out_pcplus4, exp_q[0][63:32] + 32'd4);
    end
    check("fault", 32'(fault), 32'(m_fault));
    check("fault_pc", fault_pc, m_fault_pc);
    check("state", 32'(dbg_state), m_fault ? 32'(FAULT) : 32'(FETCH));
    if (!m_fault) check("imem_address", imem_address, m_pc);
  end

  // ---------------- stimulus ----------------
  task automatic do_redirect(input logic [31:0] target);
    redirect = 1'b1;
    redirect_pc = target;
  endtask

  function automatic logic [31:0] rand_target();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 5) return {21'd0, 9'($urandom_range(0, 511)), 2'b00};
    if (sel == 6) return 32'h7F0 + 32'(4 * $urandom_range(0, 3));
    if (sel == 7) return {21'd0, 9'($urandom_range(0, 511)), 2'($urandom_range(1, 3))};
    if (sel == 8) return 32'h800 + 32'(4 * $urandom_range(0, 15));
    return $urandom;
  endfunction

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'(i * 3);

    // reset values
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_pcplus4", out_pcplus4, 32'd4);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_pc", fault_pc, 32'd0);
    check("rst_address", imem_address, 32'd0);

    // 1: streaming at one instruction per cycle
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_pc0", out_pc, 32'd0);
    check("t1_instr0", out_instr, 32'd0);
    @(negedge clk);
    check("t1_pc1", out_pc, 32'd4);
    check("t1_instr1", out_instr, 32'd3);
    @(negedge clk);
    check("t1_pc2", out_pc, 32'd8);
    check("t1_instr2", out_instr, 32'd6);

    // 2: backpressure after restart
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("t2_first_pc", out_pc, 32'd0);
    repeat (5) @(negedge clk);
    check("t2_addr_stall", imem_address, 32'd8);
    check("t2_head_held", out_pc, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("t2_pc4", out_pc, 32'd4);
    @(negedge clk);
    check("t2_pc8", out_pc, 32'd8);

    // 3: redirect while head 0x8 is accepted
    do_redirect(32'h40);
    @(negedge clk);
    redirect = 1'b0;
    check("t3_bubble", 32'(out_valid), 32'd0);
    check("t3_addr", imem_address, 32'h40);
    @(negedge clk);
    check("t3_pc", out_pc, 32'h40);
    check("t3_instr", out_instr, 32'd48);

    // 4: misaligned redirect traps, legal redirect recovers
    do_redirect(32'h42);
    @(negedge clk);
    redirect = 1'b0;
    check("t4_fault", 32'(fault), 32'd1);
    check("t4_fault_pc", fault_pc, 32'h42);
    repeat (3) @(negedge clk);
    check("t4_no_push", 32'(out_valid), 32'd0);
    do_redirect(32'h10);
    @(negedge clk);
    redirect = 1'b0;
    check("t4_cleared", 32'(fault), 32'd0);
    check("t4_pc_held", fault_pc, 32'h42);
    @(negedge clk);
    check("t4_pc", out_pc, 32'h10);

    // 5: last word then sequential overrun
    do_redirect(32'h7FC);
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    check("t5_last_pc", out_pc, 32'h7FC);
    @(negedge clk);
    check("t5_fault", 32'(fault), 32'd1);
    check("t5_fault_pc", fault_pc, 32'h800);
    check("t5_drained", 32'(out_valid), 32'd0);

    // 6: asynchronous reset between edges with two entries queued
    do_redirect(32'h100);
    out_ready = 1'b0;
    @(negedge clk);
    redirect = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_queued_pc", out_pc, 32'h100);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_out_pc", out_pc, 32'd0);
    check("t6_pcplus4", out_pcplus4, 32'd4);
    check("t6_address", imem_address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_restart_pc", out_pc, 32'd0);

    // random traffic on random memory contents
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 11) == 0);
      redirect_pc = rand_target();
    end
    @(negedge clk);
    rst_n = 1'b1;
    redirect = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
